regs_access_ctrl: RTL
=====================

Name: regs_access_ctrl

Overview:
- Core-side controller for the 16x32 synchronous-read register file (`regs`). It drives the file's read ports, write port and write enable.
- Accepts operand-fetch requests from decode and absorbs the 1-cycle read latency of the file.
- Forwards same-cycle writebacks and keeps a busy scoreboard so decode never receives a stale operand.
- Sits between decode/issue, execute, and writeback.

Parameters:
- FWD_EN, 1: 1 = forward the writeback captured in the read cycle; 0 = treat the writeback cycle as a hazard and stall instead.
- NREGS, 16: register count (RV32E); address width is clog2(NREGS) = 4.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- iss_valid  in  1  decode presents a request
- iss_ready  out  1  controller accepts the request this cycle
- iss_rs1adr  in  4  source address 1
- iss_rs2adr  in  4  source address 2
- iss_rdadr  in  4  destination address
- iss_rdwr  in  1  instruction writes rd
- op_valid  out  1  operand bundle valid
- op_ready  in  1  execute consumes the bundle
- op_rs1  out  32  operand 1
- op_rs2  out  32  operand 2
- op_rdadr  out  4  destination, passed through from issue
- op_rdwr  out  1  rd-write flag, passed through from issue
- wb_valid  in  1  writeback request; always accepted
- wb_rdadr  in  4  writeback address
- wb_data  in  32  writeback data
- rf_regwrite  out  1  to regs.regwrite
- rf_rdadr  out  4  to regs.rdadr
- rf_rd  out  32  to regs.rd
- rf_rs1adr  out  4  to regs.rs1adr
- rf_rs2adr  out  4  to regs.rs2adr
- rf_rs1  in  32  from regs.rs1
- rf_rs2  in  32  from regs.rs2

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-high.
- Reset: state=IDLE, busy=0, op_valid=0, op_rs1=op_rs2=0, op_rdadr=0, op_rdwr=0, address latches=0, fwd flags=0.
- Reset mid-operation: any in-flight bundle is dropped and busy is cleared. The regs block is reset by the top-level in the same cycle.
- Write path is combinational passthrough:
  - rf_regwrite = wb_valid && wb_rdadr!=0 && !reset.
  - rf_rdadr = wb_rdadr; rf_rd = wb_data.
- Scoreboard: busy[15:0].
  - Set: bit iss_rdadr is set on issue accept when iss_rdwr=1 and rdadr!=0.
  - Clear: bit wb_rdadr is cleared on wb_valid.
  - Same address set and cleared in the same cycle: set wins.
  - busy[0] is constantly 0.
- Hazard = iss_valid and any of:
  - busy[rs1] or busy[rs2], with rs!=0;
  - iss_rdwr && busy[rd] (WAW);
  - FWD_EN=0 and wb_valid with wb_rdadr equal to a nonzero rs1/rs2.
- Issue acceptance: iss_ready = !reset && !hazard && (state==IDLE || (state==HOLD && op_ready)).
- FSM states and transitions:
  - IDLE → READ on accept.
  - READ → HOLD, unconditional.
  - HOLD → READ on accept while op_ready.
  - HOLD → IDLE on op_ready without accept.
  - HOLD → HOLD otherwise.
- Read timing:
  - Accept cycle N: rf_rs1adr/rf_rs2adr come combinationally from iss_rs*adr. Outside accept cycles they show the latched addresses.
  - Also in cycle N, the controller latches rs*adr, rdadr and rdwr.
  - fwd1 is latched as wb_valid && wb_rdadr==rs1 && rs1!=0. fwd2 is latched the same way for rs2. The wb_data value is latched with them.
  - Cycle N+1 (READ): op_rs* <= fwd ? latched wb_data : rf_rs*.
  - Cycle N+2: op_valid=1. Issue-to-operand latency is 2 cycles.
  - Throughput: one request every 2 cycles when op_ready is held high.
- Handshake rules:
  - op_* outputs are stable while op_valid && !op_ready.
  - op_valid falls the cycle after consumption unless a new READ completes.
  - iss_valid may drop without acceptance; the controller has no side effects until accept.
- Boundary cases:
  - A wb to x0 is ignored and never forwarded; x0 reads yield the regs value, which is 0.
  - wb_valid concurrent with a HOLD stall is legal. Held operands are unaffected, because sources were non-busy at accept.

Decomposition:
- Package regs_pkg:
  - REG_AW=4, NREGS=16;
  - typedef regadr_t (logic [3:0]);
  - typedef word_t (logic [31:0]);
  - enum acc_state_t {IDLE, READ, HOLD}.
- One sub-module, regs_scoreboard: busy vector, set/clear priority, hazard compare.

Test Plan:
- Reset, then issue rs1=1, rs2=2 with regs x1=5, x2=7 preloaded via wb → op_valid exactly 2 cycles after accept, op_rs1=5, op_rs2=7.
- Issue rd=3 with rdwr=1, then issue rs1=3 → iss_ready=0 until wb_valid rdadr=3 data=0xDEADBEEF. Next issue gets op_rs1=0xDEADBEEF.
- With FWD_EN=1: accept rs2=4 in the same cycle as wb rdadr=4 data=0x1234 → op_rs2=0x1234 (the old value must not appear).
- wb_valid rdadr=0 data=0xFFFFFFFF → rf_regwrite=0. A later read of rs1=0 gives op_rs1=0.
- op_ready held 0 for 5 cycles → op_* stable, iss_ready=0. Raise op_ready together with iss_valid → back-to-back HOLD→READ, no bubble beyond 1 cycle.
- Assert reset in the READ state → next cycle op_valid=0, busy=0, state=IDLE. An issue to the former busy rd is accepted immediately.

Source files
------------

// File: rtl/regs_pkg.sv
// Shared types for the register-file access controller and its scoreboard.
package regs_pkg;
    localparam int REG_AW = 4;
    localparam int NREGS  = 16;

    typedef logic [REG_AW-1:0] regadr_t;
    typedef logic [31:0]       word_t;

    typedef enum logic [1:0] {IDLE, READ, HOLD} acc_state_t;
endpackage

// File: rtl/regs_scoreboard.sv
// Busy-bit scoreboard for pending writebacks and the issue hazard check.
module regs_scoreboard
    import regs_pkg::*;
#(
    parameter int FWD_EN = 1,
    parameter int NREGS  = 16
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    set_en,
    input  regadr_t set_adr,
    input  logic    wb_valid,
    input  regadr_t wb_rdadr,
    input  logic    iss_valid,
    input  regadr_t rs1adr,
    input  regadr_t rs2adr,
    input  regadr_t rdadr,
    input  logic    rdwr,
    output logic    hazard
);
    logic [NREGS-1:0] busy_reg;
    logic [NREGS-1:0] busy_next;

    // A new reservation beats a writeback retiring the same register.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                assign busy_next[gi] = 1'b0;
            end else begin : g_bit
                assign busy_next[gi] = (set_en && set_adr == regadr_t'(gi)) ? 1'b1 :
                                       (wb_valid && wb_rdadr == regadr_t'(gi)) ? 1'b0 :
                                       busy_reg[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    logic rs1_busy, rs2_busy, rd_busy, wb_hit;

    always_comb begin
        rs1_busy = (rs1adr != '0) && busy_reg[rs1adr];
        rs2_busy = (rs2adr != '0) && busy_reg[rs2adr];
        rd_busy  = rdwr && busy_reg[rdadr];
        // Without forwarding, a writeback landing in the read cycle would be missed.
        wb_hit   = (FWD_EN == 0) && wb_valid && (wb_rdadr != '0) &&
                   ((wb_rdadr == rs1adr) || (wb_rdadr == rs2adr));
        hazard   = iss_valid && (rs1_busy || rs2_busy || rd_busy || wb_hit);
    end
endmodule

// File: rtl/regs_access_ctrl.sv
// Operand-fetch controller in front of the synchronous-read register file:
// absorbs read latency, forwards same-cycle writebacks, stalls on busy registers.
module regs_access_ctrl
    import regs_pkg::*;
#(
    parameter int FWD_EN = 1,
    parameter int NREGS  = 16
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    iss_valid,
    output logic    iss_ready,
    input  regadr_t iss_rs1adr,
    input  regadr_t iss_rs2adr,
    input  regadr_t iss_rdadr,
    input  logic    iss_rdwr,
    output logic    op_valid,
    input  logic    op_ready,
    output word_t   op_rs1,
    output word_t   op_rs2,
    output regadr_t op_rdadr,
    output logic    op_rdwr,
    input  logic    wb_valid,
    input  regadr_t wb_rdadr,
    input  word_t   wb_data,
    output logic    rf_regwrite,
    output regadr_t rf_rdadr,
    output word_t   rf_rd,
    output regadr_t rf_rs1adr,
    output regadr_t rf_rs2adr,
    input  word_t   rf_rs1,
    input  word_t   rf_rs2
);
    acc_state_t state_reg, state_next;
    logic       hazard, accept, set_en, fwd_ok;

    regadr_t rs1_reg, rs2_reg, rd_reg;
    logic    rdwr_reg, fwd1_reg, fwd2_reg;
    word_t   wbd_reg;

    word_t   op_rs1_reg, op_rs2_reg;
    regadr_t op_rdadr_reg;
    logic    op_rdwr_reg, op_valid_reg;

    regs_scoreboard #(.FWD_EN(FWD_EN), .NREGS(NREGS)) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .set_en    (set_en),
        .set_adr   (iss_rdadr),
        .wb_valid  (wb_valid),
        .wb_rdadr  (wb_rdadr),
        .iss_valid (iss_valid),
        .rs1adr    (iss_rs1adr),
        .rs2adr    (iss_rs2adr),
        .rdadr     (iss_rdadr),
        .rdwr      (iss_rdwr),
        .hazard    (hazard)
    );

    assign iss_ready = !reset && !hazard &&
                       (state_reg == IDLE || (state_reg == HOLD && op_ready));
    assign accept    = iss_valid && iss_ready;
    assign set_en    = accept && iss_rdwr && (iss_rdadr != '0);
    assign fwd_ok    = (FWD_EN != 0) && wb_valid && (wb_rdadr != '0);

    assign rf_regwrite = wb_valid && (wb_rdadr != '0) && !reset;
    assign rf_rdadr    = wb_rdadr;
    assign rf_rd       = wb_data;
    // The file samples its read address at the accept edge, so steer it straight from issue.
    assign rf_rs1adr   = accept ? iss_rs1adr : rs1_reg;
    assign rf_rs2adr   = accept ? iss_rs2adr : rs2_reg;

    assign op_valid = op_valid_reg;
    assign op_rs1   = op_rs1_reg;
    assign op_rs2   = op_rs2_reg;
    assign op_rdadr = op_rdadr_reg;
    assign op_rdwr  = op_rdwr_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = READ;
            READ:    state_next = HOLD;
            HOLD:    if (op_ready) state_next = accept ? READ : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            rs1_reg      <= '0;
            rs2_reg      <= '0;
            rd_reg       <= '0;
            rdwr_reg     <= 1'b0;
            fwd1_reg     <= 1'b0;
            fwd2_reg     <= 1'b0;
            wbd_reg      <= '0;
            op_rs1_reg   <= '0;
            op_rs2_reg   <= '0;
            op_rdadr_reg <= '0;
            op_rdwr_reg  <= 1'b0;
            op_valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                rs1_reg  <= iss_rs1adr;
                rs2_reg  <= iss_rs2adr;
                rd_reg   <= iss_rdadr;
                rdwr_reg <= iss_rdwr;
                fwd1_reg <= fwd_ok && (wb_rdadr == iss_rs1adr);
                fwd2_reg <= fwd_ok && (wb_rdadr == iss_rs2adr);
                wbd_reg  <= wb_data;
            end
            if (state_reg == READ) begin
                op_rs1_reg   <= fwd1_reg ? wbd_reg : rf_rs1;
                op_rs2_reg   <= fwd2_reg ? wbd_reg : rf_rs2;
                op_rdadr_reg <= rd_reg;
                op_rdwr_reg  <= rdwr_reg;
                op_valid_reg <= 1'b1;
            end else if (state_reg == HOLD && op_ready) begin
                op_valid_reg <= 1'b0;
            end
        end
    end
endmodule
